// File: rtl/decode_stage.sv
// Registered instruction decode stage with valid/ready handshake.
// Optional upper-immediate prefix builds a double-width immediate.
package lib_cpu;
    typedef enum logic [3:0] {
        INVALID,
        MOV_A_B,
        MOV_B_A,
        MOV_A_IMM,
        MOV_B_IMM,
        IN_A,
        IN_B,
        OUT_B,
        OUT_IMM,
        ADD_A_IMM,
        ADD_B_IMM,
        JMP_IMM,
        JNC_IMM
    } OPECODE;
endpackage

module decode_stage
    import lib_cpu::*;
#(
    parameter int IMM_W  = 4,
    parameter bit EXT_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IMM_W+3:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output OPECODE             out_opecode,
    output logic [2*IMM_W-1:0] out_imm,
    output logic               out_ext
);

    typedef enum logic {IDLE, PREFIX} state_t;

    state_t             state_q, state_d;
    logic [IMM_W-1:0]   upper_q, upper_d;
    logic               valid_d;
    OPECODE             op_d;
    logic [2*IMM_W-1:0] imm_d;
    logic               ext_d;

    logic [3:0]       op;
    logic [IMM_W-1:0] imm;
    logic             accept;
    logic             is_pfx;
    OPECODE           dec;
    logic             has_imm;

    assign op     = in_data[IMM_W+3:IMM_W];
    assign imm    = in_data[IMM_W-1:0];
    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept = in_valid && in_ready;
    assign is_pfx = EXT_EN && (op == 4'b1000);

    always_comb begin
        dec = INVALID;
        unique case (op)
            4'b0001: dec = MOV_A_B;
            4'b0100: dec = MOV_B_A;
            4'b0011: dec = MOV_A_IMM;
            4'b0111: dec = MOV_B_IMM;
            4'b0010: dec = IN_A;
            4'b0110: dec = IN_B;
            4'b1001: dec = OUT_B;
            4'b1011: dec = OUT_IMM;
            4'b0000: dec = ADD_A_IMM;
            4'b0101: dec = ADD_B_IMM;
            4'b1111: dec = JMP_IMM;
            4'b1110: dec = JNC_IMM;
            default: dec = INVALID;
        endcase
    end

    always_comb begin
        has_imm = 1'b0;
        unique case (dec)
            MOV_A_IMM, MOV_B_IMM, OUT_IMM,
            ADD_A_IMM, ADD_B_IMM,
            JMP_IMM, JNC_IMM: has_imm = 1'b1;
            default:          has_imm = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        upper_d = upper_q;
        valid_d = out_valid && !out_ready;
        op_d    = out_opecode;
        imm_d   = out_imm;
        ext_d   = out_ext;
        if (flush) begin
            valid_d = 1'b0;
            state_d = IDLE;
        end else if (accept) begin
            unique case (state_q)
                IDLE: begin
                    if (is_pfx) begin
                        upper_d = imm;
                        state_d = PREFIX;
                    end else begin
                        valid_d = 1'b1;
                        op_d    = dec;
                        imm_d   = {{IMM_W{1'b0}}, imm};
                        ext_d   = 1'b0;
                    end
                end
                PREFIX: begin
                    // a second prefix is not chained; pair is INVALID
                    valid_d = 1'b1;
                    op_d    = has_imm ? dec : INVALID;
                    imm_d   = {upper_q, imm};
                    ext_d   = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            upper_q     <= '0;
            out_valid   <= 1'b0;
            out_opecode <= INVALID;
            out_imm     <= '0;
            out_ext     <= 1'b0;
        end else begin
            state_q     <= state_d;
            upper_q     <= upper_d;
            out_valid   <= valid_d;
            out_opecode <= op_d;
            out_imm     <= imm_d;
            out_ext     <= ext_d;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed vector bench for decode_stage, with and without
// the prefix extension enabled.
module tb_decode_stage;
    import lib_cpu::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       fl1, iv1, ir1, ov1, or1, ex1;
    logic [7:0] id1, im1;
    OPECODE     op1;
    logic       fl0, iv0, ir0, ov0, or0, ex0;
    logic [7:0] id0, im0;
    OPECODE     op0;

    decode_stage #(.IMM_W(4), .EXT_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(fl1),
        .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1),
        .out_opecode(op1), .out_imm(im1), .out_ext(ex1)
    );

    decode_stage #(.IMM_W(4), .EXT_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(fl0),
        .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .out_valid(ov0), .out_ready(or0),
        .out_opecode(op0), .out_imm(im0), .out_ext(ex0)
    );

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       fl;
        logic       rdy;
        logic       vld;
        logic       chk;
        OPECODE     op;
        logic [7:0] imm;
        logic       ext;
    } vec_t;

    vec_t tv1[$];
    vec_t tv0[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(
        logic iv, logic [7:0] d, logic ordy, logic fl,
        logic rdy, logic vld, logic chk,
        OPECODE op, logic [7:0] imm, logic ext);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
        v.rdy = rdy; v.vld = vld; v.chk = chk;
        v.op = op; v.imm = imm; v.ext = ext;
        return v;
    endfunction

    task automatic cmp(string nm, int idx,
                       logic [7:0] act, logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s #%0d: got %h want %h",
                     nm, idx, act, exp);
        end
    endtask

    task automatic drive(bit sel, logic iv, logic [7:0] d,
                         logic ordy, logic fl);
        if (sel) begin
            iv0 = iv; id0 = d; or0 = ordy; fl0 = fl;
        end else begin
            iv1 = iv; id1 = d; or1 = ordy; fl1 = fl;
        end
    endtask

    task automatic apply(bit sel, vec_t v, int idx);
        drive(sel, v.iv, v.d, v.ordy, v.fl);
        #1;
        cmp("in_ready", idx, sel ? ir0 : ir1, v.rdy);
        @(posedge clk);
        #1;
        cmp("out_valid", idx, sel ? ov0 : ov1, v.vld);
        if (v.chk) begin
            cmp("opecode", idx,
                8'(sel ? op0 : op1), 8'(v.op));
            cmp("imm", idx, sel ? im0 : im1, v.imm);
            cmp("ext", idx, sel ? ex0 : ex1, v.ext);
        end
    endtask

    task automatic chk_reset(int idx);
        cmp("rst_valid", idx, ov1, 0);
        cmp("rst_op", idx, 8'(op1), 8'(INVALID));
        cmp("rst_imm", idx, im1, 0);
        cmp("rst_ext", idx, ex1, 0);
    endtask

    initial begin
        // iv data ordy fl | rdy vld chk op imm ext
        tv1.push_back(mk(1,8'h35,1,0, 1,1,1,MOV_A_IMM,8'h05,0));
        tv1.push_back(mk(1,8'h8A,1,0, 1,0,0,INVALID,8'h00,0));
        tv1.push_back(mk(1,8'hB3,1,0, 1,1,1,OUT_IMM,8'hA3,1));
        tv1.push_back(mk(1,8'h8A,1,0, 1,0,0,INVALID,8'h00,0));
        tv1.push_back(mk(1,8'h10,1,0, 1,1,1,INVALID,8'hA0,1));
        tv1.push_back(mk(1,8'hF7,1,0, 1,1,1,JMP_IMM,8'h07,0));
        tv1.push_back(mk(0,8'h00,1,0, 1,0,0,INVALID,8'h00,0));
        tv1.push_back(mk(1,8'h01,0,0, 1,1,1,ADD_A_IMM,8'h01,0));
        tv1.push_back(mk(1,8'h72,0,0, 0,1,1,ADD_A_IMM,8'h01,0));
        tv1.push_back(mk(1,8'h72,0,0, 0,1,1,ADD_A_IMM,8'h01,0));
        tv1.push_back(mk(1,8'h72,0,0, 0,1,1,ADD_A_IMM,8'h01,0));
        tv1.push_back(mk(1,8'h72,1,0, 1,1,1,MOV_B_IMM,8'h02,0));
        tv1.push_back(mk(0,8'h00,1,0, 1,0,0,INVALID,8'h00,0));
        tv1.push_back(mk(1,8'h8A,1,0, 1,0,0,INVALID,8'h00,0));
        tv1.push_back(mk(1,8'h52,1,1, 0,0,0,INVALID,8'h00,0));
        tv1.push_back(mk(1,8'h52,1,0, 1,1,1,ADD_B_IMM,8'h02,0));
        tv1.push_back(mk(1,8'h33,1,0, 1,1,1,MOV_A_IMM,8'h03,0));
        tv1.push_back(mk(0,8'h00,0,1, 0,0,0,INVALID,8'h00,0));
        tv1.push_back(mk(1,8'h36,1,0, 1,1,1,MOV_A_IMM,8'h06,0));
        tv1.push_back(mk(1,8'hF1,1,0, 1,1,1,JMP_IMM,8'h01,0));
        tv1.push_back(mk(1,8'hE2,1,0, 1,1,1,JNC_IMM,8'h02,0));
        tv1.push_back(mk(1,8'h94,1,0, 1,1,1,OUT_B,8'h04,0));
        tv1.push_back(mk(1,8'h1C,1,0, 1,1,1,MOV_A_B,8'h0C,0));
        tv1.push_back(mk(1,8'h8A,1,0, 1,0,0,INVALID,8'h00,0));
        tv1.push_back(mk(1,8'h85,1,0, 1,1,1,INVALID,8'hA5,1));
        tv1.push_back(mk(1,8'h8C,1,0, 1,0,0,INVALID,8'h00,0));
        tv1.push_back(mk(1,8'h26,1,0, 1,1,1,INVALID,8'hC6,1));
        tv1.push_back(mk(0,8'h00,1,0, 1,0,0,INVALID,8'h00,0));

        tv0.push_back(mk(1,8'h8A,1,0, 1,1,1,INVALID,8'h0A,0));
        tv0.push_back(mk(1,8'hA3,1,0, 1,1,1,INVALID,8'h03,0));
        tv0.push_back(mk(1,8'hC1,1,0, 1,1,1,INVALID,8'h01,0));
        tv0.push_back(mk(1,8'hD2,1,0, 1,1,1,INVALID,8'h02,0));
        tv0.push_back(mk(1,8'h35,1,0, 1,1,1,MOV_A_IMM,8'h05,0));
        tv0.push_back(mk(1,8'h64,1,0, 1,1,1,IN_B,8'h04,0));

        rst_n = 1'b0;
        drive(0, 0, 8'h00, 1, 0);
        drive(1, 0, 8'h00, 1, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_reset(0);
        cmp("rst_valid0", 0, ov0, 0);
        cmp("rst_ready", 0, ir1, 1);
        rst_n = 1'b1;

        foreach (tv1[i]) apply(0, tv1[i], i);
        foreach (tv0[i]) apply(1, tv0[i], 100 + i);

        // reset in the middle of a prefix pair
        apply(0, mk(1,8'h8A,1,0, 1,0,0,INVALID,8'h00,0), 200);
        drive(0, 0, 8'h00, 1, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_reset(201);
        rst_n = 1'b1;
        apply(0, mk(1,8'h52,1,0, 1,1,1,ADD_B_IMM,8'h02,0), 202);
        apply(0, mk(0,8'h00,1,0, 1,0,0,INVALID,8'h00,0), 203);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered, handshaked instruction-decode stage for the CPU core. It is the parametrised successor to the combinational opcode decoder.
- Accepts one instruction word per valid/ready transfer and decodes the 4-bit opcode field into an OPECODE value from lib_cpu. The opcode map is unchanged.
- Widens the immediate to IMM_W bits.
- Adds an optional two-word prefix mode that concatenates a double-width immediate.
- Sits between instruction fetch (upstream) and the execute/ALU control (downstream).

Parameters:
IMM_W, 4, immediate field width; instruction word is IMM_W+4 bits, opcode in the top 4 bits.
EXT_EN, 1, 1 enables prefix opcode 4'b1000 (upper-immediate prefix); 0 decodes 4'b1000 as INVALID.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous reset, active-low
flush  in  1  synchronous pipeline flush (branch taken)
in_valid  in  1  upstream word valid
in_ready  out  1  stage can accept a word this cycle
in_data  in  IMM_W+4  instruction word: [IMM_W+3:IMM_W] opcode, [IMM_W-1:0] immediate
out_valid  out  1  decoded instruction valid
out_ready  in  1  downstream accepts decoded instruction
out_opecode  out  OPECODE  decoded operation
out_imm  out  2*IMM_W  immediate, zero-extended or prefix-concatenated
out_ext  out  1  1 = out_imm built from a prefix word

Behaviour:
- Reset (rst_n=0 at clk edge): out_valid=0, out_opecode=INVALID, out_imm=0, out_ext=0, FSM=IDLE, held upper-immediate register=0. Reset aborts any pending prefix.
- Transfer rules: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- in_ready = !flush && (!out_valid || out_ready). Combinational; no skid buffer.
- While out_valid && !out_ready, all out_* are held stable.
- Opcode map:
  - 0001 MOV_A_B, 0100 MOV_B_A, 0011 MOV_A_IMM, 0111 MOV_B_IMM
  - 0010 IN_A, 0110 IN_B, 1001 OUT_B, 1011 OUT_IMM
  - 0000 ADD_A_IMM, 0101 ADD_B_IMM, 1111 JMP_IMM, 1110 JNC_IMM
  - All others: INVALID.
- Immediate-bearing set: MOV_A_IMM, MOV_B_IMM, OUT_IMM, ADD_A_IMM, ADD_B_IMM, JMP_IMM, JNC_IMM.
- FSM state IDLE:
  - Accepted word with opcode 1000 and EXT_EN=1: store imm as upper half, go to PREFIX. No output is produced.
  - Any other accepted word: next cycle out_valid=1, out_opecode=decode, out_imm={IMM_W'0, imm}, out_ext=0. Latency is 1 cycle.
  - Non-immediate opcodes still pass imm through unchanged; downstream ignores it.
- FSM state PREFIX:
  - The next accepted word completes the pair: out_imm={upper, imm}, out_ext=1, go to IDLE.
  - If that opcode is immediate-bearing, out_opecode=decode.
  - Otherwise out_opecode=INVALID. This includes a second prefix, which is not chained.
- EXT_EN=0: opcode 1000 produces a single-word INVALID with out_ext=0. FSM never leaves IDLE.
- Flush (rst_n=1, flush=1):
  - Clears out_valid and returns FSM to IDLE. Held upper register is don't-care.
  - in_ready=0 that cycle, so no word is accepted.
  - An output transfer coinciding with flush is considered completed.
- Priority: reset > flush > normal operation.
- Back-to-back: with out_ready held 1, one word is accepted per cycle and out_valid stays 1 continuously. Prefix cycles create a 1-cycle bubble.

Test Plan:
1. IMM_W=4, after reset, in_data=0x35, out_ready=1 -> next cycle out_valid=1, MOV_A_IMM, out_imm=0x05, out_ext=0; reset values checked before stimulus.
2. In_data=0x8A then 0xB3 -> no out_valid after 0x8A; after 0xB3: OUT_IMM, out_imm=0xA3, out_ext=1.
3. In_data=0x8A then 0x10 -> INVALID, out_imm=0xA0, out_ext=1; following 0xF7 -> JMP_IMM, out_imm=0x07, out_ext=0.
4. Out_ready=0, send 0x01 then 0x72 -> ADD_A_IMM/0x01 held 3 cycles, in_ready=0; raise out_ready -> 0x72 accepted, MOV_B_IMM/0x02 next cycle.
5. 0x8A accepted, flush=1 one cycle, then 0x52 -> ADD_B_IMM, out_imm=0x02, out_ext=0; also rst_n=0 mid-PREFIX gives the same outcome.
6. EXT_EN=0: 0x8A -> INVALID, out_imm=0x0A, out_ext=0; opcodes 1000/1010/1100/1101 all INVALID.
